// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared constants for the ID/EX pipeline stage: the packing
//                of the 10-bit control word, the bubble encoding and the
//                ALUOp encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

    // Control word packing:
    // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,RegDst,ALUOp[1:0],Valid}
    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_VALID    = 0;

    // An all-zero control word is a bubble: no writes, no memory access, not valid.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // ALUOp encodings carried through to the EX-stage ALU control.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detection. Flags when the load
//                sitting in EX writes a register the ID instruction reads, and
//                derives the PC / IF-ID write enables. A flush overrides the
//                stall so a branch redirect is never blocked; during reset the
//                enables are forced high.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  reset,
    input  logic                  ex_mem_read,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  load_use,
    output logic                  pc_write,
    output logic                  if_id_write
);

    logic w_stall;

    // Load in EX targeting a non-zero register that the ID instruction reads.
    always_comb begin
        load_use    = ex_mem_read && ex_valid && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
        w_stall     = load_use && !flush && !hold;
        pc_write    = reset || !w_stall;
        if_id_write = reset || !w_stall;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with integrated load-use hazard
//                detection. Inserts one bubble per load-use pair, squashes
//                the ID instruction on Flush and freezes entirely on Hold.
//                Optional feature macro: ID_EX_PERF_CNT_EN adds saturating
//                stall/flush performance counters and their ports.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rd,
    input  logic [DATA_W-1:0]     ID_ReadData1,
    input  logic [DATA_W-1:0]     ID_ReadData2,
    input  logic [DATA_W-1:0]     ID_Imm,
    input  logic [DATA_W-1:0]     ID_PC4,
    input  logic [CTRL_W-1:0]     ID_Ctrl,
    input  logic                  Flush,
    input  logic                  Hold,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic [REG_ADDR_W-1:0] ID_EX_Rs,
    output logic [REG_ADDR_W-1:0] ID_EX_Rt,
    output logic [REG_ADDR_W-1:0] ID_EX_Rd,
    output logic [DATA_W-1:0]     ID_EX_ReadData1,
    output logic [DATA_W-1:0]     ID_EX_ReadData2,
    output logic [DATA_W-1:0]     ID_EX_Imm,
    output logic [DATA_W-1:0]     ID_EX_PC4,
    output logic [CTRL_W-1:0]     ID_EX_Ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    logic w_load_use;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .reset       (reset),
        .ex_mem_read (ID_EX_Ctrl[CTRL_MEMREAD]),
        .ex_valid    (ID_EX_Ctrl[CTRL_VALID]),
        .ex_rt       (ID_EX_Rt),
        .id_rs       (IF_ID_Rs),
        .id_rt       (IF_ID_Rt),
        .flush       (Flush),
        .hold        (Hold),
        .load_use    (w_load_use),
        .pc_write    (PCWrite),
        .if_id_write (IF_ID_Write)
    );

    // Pipeline register: reset > Hold > Flush > load-use bubble > normal load.
    // A load-use bubble also clears the specifiers so it cannot match in forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_Imm       <= '0;
            ID_EX_PC4       <= '0;
            ID_EX_Ctrl      <= CTRL_BUBBLE;
        end else if (!Hold) begin
            ID_EX_ReadData1 <= ID_ReadData1;
            ID_EX_ReadData2 <= ID_ReadData2;
            ID_EX_Imm       <= ID_Imm;
            ID_EX_PC4       <= ID_PC4;
            if (Flush) begin
                ID_EX_Rs   <= IF_ID_Rs;
                ID_EX_Rt   <= IF_ID_Rt;
                ID_EX_Rd   <= IF_ID_Rd;
                ID_EX_Ctrl <= CTRL_BUBBLE;
            end else if (w_load_use) begin
                ID_EX_Rs   <= '0;
                ID_EX_Rt   <= '0;
                ID_EX_Rd   <= '0;
                ID_EX_Ctrl <= CTRL_BUBBLE;
            end else begin
                ID_EX_Rs   <= IF_ID_Rs;
                ID_EX_Rt   <= IF_ID_Rt;
                ID_EX_Rd   <= IF_ID_Rd;
                ID_EX_Ctrl <= ID_Ctrl;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating event counters; frozen on Hold, a flush takes precedence over a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!Hold) begin
            if (Flush) begin
                if (!(&flush_count)) begin
                    flush_count <= flush_count + CNT_ONE;
                end
            end else if (w_load_use) begin
                if (!(&stall_count)) begin
                    stall_count <= stall_count + CNT_ONE;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: directed hazard, flush,
//                hold and reset scenarios plus randomized traffic against a
//                behavioural model. Counter checks apply when the
//                ID_EX_PERF_CNT_EN macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 10;
    localparam int TCW = 4;
    localparam int CNT_MAX = (1 << TCW) - 1;

    // Control words built from the documented packing
    localparam logic [CW-1:0] LW_CTRL  = 10'h391; // RegWrite,MemtoReg,MemRead,ALUSrc,Valid
    localparam logic [CW-1:0] ADD_CTRL = 10'h20D; // RegWrite,RegDst,ALUOp=10,Valid
    localparam logic [CW-1:0] SW_CTRL  = 10'h051; // MemWrite,ALUSrc,Valid

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
    logic [CW-1:0] ID_Ctrl;
    logic          Flush, Hold;
    logic          PCWrite, IF_ID_Write;
    logic [AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
    logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4;
    logic [CW-1:0] ID_EX_Ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [TCW-1:0] stall_count, flush_count;
`endif

    id_ex_stage #(
        .DATA_W     (DW),
        .REG_ADDR_W (AW)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .CNT_W      (TCW)
`endif
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_Rs        (IF_ID_Rs),
        .IF_ID_Rt        (IF_ID_Rt),
        .IF_ID_Rd        (IF_ID_Rd),
        .ID_ReadData1    (ID_ReadData1),
        .ID_ReadData2    (ID_ReadData2),
        .ID_Imm          (ID_Imm),
        .ID_PC4          (ID_PC4),
        .ID_Ctrl         (ID_Ctrl),
        .Flush           (Flush),
        .Hold            (Hold),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Rs        (ID_EX_Rs),
        .ID_EX_Rt        (ID_EX_Rt),
        .ID_EX_Rd        (ID_EX_Rd),
        .ID_EX_ReadData1 (ID_EX_ReadData1),
        .ID_EX_ReadData2 (ID_EX_ReadData2),
        .ID_EX_Imm       (ID_EX_Imm),
        .ID_EX_PC4       (ID_EX_PC4),
        .ID_EX_Ctrl      (ID_EX_Ctrl)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of what EX should hold
    logic [AW-1:0] m_rs, m_rt, m_rd;
    logic [DW-1:0] m_d1, m_d2, m_imm, m_pc4;
    logic [CW-1:0] m_ctrl;
    bit            m_spec_known, m_dp_known;
    int            m_stall, m_flush;

    // Load in EX (MemRead bit 7, Valid bit 0) writing a non-zero register read by ID
    function automatic bit model_lu();
        return m_ctrl[7] && m_ctrl[0] && (m_rt != 0) &&
               ((m_rt == IF_ID_Rs) || (m_rt == IF_ID_Rt));
    endfunction

    function automatic bit model_pcwrite();
        return reset || !(model_lu() && !Flush && !Hold);
    endfunction

    // Advance one clock and apply the stage rules to the model
    task automatic tick();
        bit lu;
        @(posedge clk);
        lu = model_lu();
        if (reset) begin
            m_rs = 0; m_rt = 0; m_rd = 0;
            m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc4 = 0;
            m_ctrl = 0; m_stall = 0; m_flush = 0;
            m_spec_known = 1; m_dp_known = 1;
        end else if (!Hold) begin
            m_d1 = ID_ReadData1; m_d2 = ID_ReadData2; m_imm = ID_Imm; m_pc4 = ID_PC4;
            if (Flush) begin
                m_ctrl = 0; m_spec_known = 0; m_dp_known = 0;
                m_rs = IF_ID_Rs; m_rt = IF_ID_Rt; m_rd = IF_ID_Rd;
                if (m_flush < CNT_MAX) m_flush++;
            end else if (lu) begin
                m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
                m_spec_known = 1; m_dp_known = 0;
                if (m_stall < CNT_MAX) m_stall++;
            end else begin
                m_ctrl = ID_Ctrl; m_rs = IF_ID_Rs; m_rt = IF_ID_Rt; m_rd = IF_ID_Rd;
                m_spec_known = 1; m_dp_known = 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [CW-1:0] c, input int rs, input int rt, input int rd);
        ID_Ctrl = c;
        IF_ID_Rs = AW'(rs); IF_ID_Rt = AW'(rt); IF_ID_Rd = AW'(rd);
        ID_ReadData1 = $urandom; ID_ReadData2 = $urandom;
        ID_Imm = $urandom; ID_PC4 = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1; Flush = 1'b0; Hold = 1'b0;
        drive('0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; Flush = 1'b0; Hold = 1'b0;
        drive(LW_CTRL, 1, 2, 3);
        #1;
        n_checks++;
        if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin
            n_fail++; $display("FAIL reset_enables: actual=%b%b required=11", PCWrite, IF_ID_Write);
        end
        tick();
        n_checks++;
        if ({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_Ctrl} !== '0 ||
            {ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ctrl=%h rs=%0d d1=%h required all zero",
                               ID_EX_Ctrl, ID_EX_Rs, ID_EX_ReadData1);
        end
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if (stall_count !== '0 || flush_count !== '0) begin
            n_fail++; $display("FAIL reset_counters: actual=%0d/%0d required=0/0", stall_count, flush_count);
        end
`endif
        reset = 1'b0;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_pcwrite: actual=%b required=1", PCWrite);
        end
    endtask

    // lw $2,0($1) in EX, add $3,$2,$4 in ID
    task automatic test_load_use();
        do_reset();
        drive(LW_CTRL, 1, 2, 0);
        tick();
        drive(ADD_CTRL, 2, 4, 3);
        #1;
        n_checks++;
        if (PCWrite !== 1'b0 || IF_ID_Write !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall: actual=%b%b required=00", PCWrite, IF_ID_Write);
        end
        tick();
        n_checks++;
        if (ID_EX_Ctrl !== '0 || {ID_EX_Rs, ID_EX_Rt, ID_EX_Rd} !== '0 || PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL lu_bubble: ctrl=%h rs=%0d rt=%0d rd=%0d pcw=%b required 0,0,0,0,1",
                               ID_EX_Ctrl, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, PCWrite);
        end
        tick();
        n_checks++;
        if (ID_EX_Ctrl !== ADD_CTRL || ID_EX_Rs !== 5'd2 || ID_EX_Rt !== 5'd4 || ID_EX_Rd !== 5'd3 ||
            ID_EX_ReadData1 !== ID_ReadData1) begin
            n_fail++; $display("FAIL lu_add_loads: ctrl=%h rs=%0d rt=%0d rd=%0d required %h,2,4,3",
                               ID_EX_Ctrl, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ADD_CTRL);
        end
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if (stall_count !== 4'd1) begin
            n_fail++; $display("FAIL lu_stall_count: actual=%0d required=1", stall_count);
        end
`endif
    endtask

    // lw $0 in EX, ID reads $0: no hazard
    task automatic test_zero_reg();
        do_reset();
        drive(LW_CTRL, 1, 0, 0);
        tick();
        drive(ADD_CTRL, 0, 0, 5);
        #1;
        n_checks++;
        if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin
            n_fail++; $display("FAIL zero_reg_nostall: actual=%b%b required=11", PCWrite, IF_ID_Write);
        end
        tick();
        n_checks++;
        if (ID_EX_Ctrl !== ADD_CTRL || ID_EX_Rd !== 5'd5) begin
            n_fail++; $display("FAIL zero_reg_load: ctrl=%h rd=%0d required %h,5", ID_EX_Ctrl, ID_EX_Rd, ADD_CTRL);
        end
    endtask

    // Load-use pair arriving together with Flush
    task automatic test_flush_lu();
        do_reset();
        drive(LW_CTRL, 1, 2, 0);
        tick();
        drive(ADD_CTRL, 4, 2, 3);
        Flush = 1'b1;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin
            n_fail++; $display("FAIL flush_lu_enables: actual=%b%b required=11", PCWrite, IF_ID_Write);
        end
        tick();
        Flush = 1'b0;
        n_checks++;
        if (ID_EX_Ctrl !== '0) begin
            n_fail++; $display("FAIL flush_lu_ctrl: actual=%h required=0", ID_EX_Ctrl);
        end
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
            n_fail++; $display("FAIL flush_lu_counts: flush=%0d stall=%0d required 1,0", flush_count, stall_count);
        end
`endif
    endtask

    // Hold freezes everything for three cycles, then the current inputs load
    task automatic test_hold();
        logic [DW-1:0] k_d1;
        do_reset();
        drive(ADD_CTRL, 5, 6, 7);
        k_d1 = ID_ReadData1;
        tick();
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(SW_CTRL, $urandom_range(8, 31), $urandom_range(8, 31), $urandom_range(8, 31));
            Flush = i[0];
            tick();
            n_checks++;
            if (ID_EX_Ctrl !== ADD_CTRL || ID_EX_Rs !== 5'd5 || ID_EX_Rt !== 5'd6 ||
                ID_EX_Rd !== 5'd7 || ID_EX_ReadData1 !== k_d1) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: ctrl=%h rs=%0d d1=%h required %h,5,%h",
                                   i, ID_EX_Ctrl, ID_EX_Rs, ID_EX_ReadData1, ADD_CTRL, k_d1);
            end
`ifdef ID_EX_PERF_CNT_EN
            n_checks++;
            if (flush_count !== 4'd0 || stall_count !== 4'd0) begin
                n_fail++; $display("FAIL hold_counters[%0d]: flush=%0d stall=%0d required 0,0", i, flush_count, stall_count);
            end
`endif
        end
        Hold = 1'b0; Flush = 1'b0;
        drive(SW_CTRL, 9, 10, 11);
        tick();
        n_checks++;
        if (ID_EX_Ctrl !== SW_CTRL || ID_EX_Rs !== 5'd9 || ID_EX_ReadData1 !== ID_ReadData1) begin
            n_fail++; $display("FAIL hold_release: ctrl=%h rs=%0d required %h,9", ID_EX_Ctrl, ID_EX_Rs, SW_CTRL);
        end
    endtask

    // Reset asserted while a load-use stall is active
    task automatic test_reset_mid_stall();
        do_reset();
        drive(LW_CTRL, 1, 2, 0);
        tick();
        drive(ADD_CTRL, 2, 4, 3);
        #1;
        n_checks++;
        if (PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall_pre: actual=%b required=0", PCWrite);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL rst_stall_pcwrite: actual=%b required=1", PCWrite);
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ID_EX_Ctrl !== '0 || {ID_EX_Rs, ID_EX_Rt, ID_EX_Rd} !== '0 ||
            ID_EX_ReadData1 !== '0 || PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL rst_stall_outputs: ctrl=%h rt=%0d d1=%h pcw=%b required 0,0,0,1",
                               ID_EX_Ctrl, ID_EX_Rt, ID_EX_ReadData1, PCWrite);
        end
    endtask

    // lw $2 ; lw $3,0($2) ; add $4,$3,$5 -- one bubble per dependent pair
    task automatic test_back_to_back();
        int bubbles = 0;
        do_reset();
        drive(LW_CTRL, 1, 2, 0);
        tick();
        drive(LW_CTRL, 2, 3, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (PCWrite === 1'b0) bubbles++;
            tick();
            if (ID_EX_Ctrl === LW_CTRL && ID_EX_Rt === 5'd3) break;
        end
        drive(ADD_CTRL, 3, 5, 4);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (PCWrite === 1'b0) bubbles++;
            tick();
            if (ID_EX_Ctrl === ADD_CTRL) break;
        end
        n_checks++;
        if (bubbles !== 2) begin
            n_fail++; $display("FAIL b2b_bubbles: actual=%0d required=2", bubbles);
        end
        n_checks++;
        if (ID_EX_Ctrl !== ADD_CTRL || ID_EX_Rs !== 5'd3) begin
            n_fail++; $display("FAIL b2b_final: ctrl=%h rs=%0d required %h,3", ID_EX_Ctrl, ID_EX_Rs, ADD_CTRL);
        end
    endtask

    // 20 load-use stalls against a 4-bit counter
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(LW_CTRL, 1, 2, 0);
            tick();
            drive(ADD_CTRL, 2, 6, 7);
            tick();
            n_checks++;
            if (ID_EX_Ctrl !== '0) begin
                n_fail++; $display("FAIL sat_bubble[%0d]: ctrl=%h required=0", i, ID_EX_Ctrl);
            end
            tick();
`ifdef ID_EX_PERF_CNT_EN
            if (i == 9 || i == 14 || i == 19) begin
                n_checks++;
                if (int'(stall_count) != ((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)) begin
                    n_fail++; $display("FAIL sat_count[%0d]: actual=%0d required=%0d", i, stall_count,
                                       (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
                end
            end
`endif
        end
    endtask

    // Randomized traffic compared against the model every cycle
    task automatic test_random();
        logic [CW-1:0] c;
        for (int i = 0; i < 400; i++) begin
            c = CW'($urandom);
            c[7] = ($urandom_range(0, 1) == 1);
            c[0] = ($urandom_range(0, 3) != 0);
            drive(c, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
            Flush = ($urandom_range(0, 7) == 0);
            Hold  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            #1;
            n_checks++;
            if (PCWrite !== model_pcwrite() || IF_ID_Write !== model_pcwrite()) begin
                n_fail++; $display("FAIL rnd_enables[%0d]: actual=%b%b required=%b", i, PCWrite, IF_ID_Write, model_pcwrite());
            end
            tick();
            n_checks++;
            if (ID_EX_Ctrl !== m_ctrl) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d]: actual=%h required=%h", i, ID_EX_Ctrl, m_ctrl);
            end
            if (m_spec_known) begin
                n_checks++;
                if ({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd} !== {m_rs, m_rt, m_rd}) begin
                    n_fail++; $display("FAIL rnd_spec[%0d]: actual=%0d,%0d,%0d required=%0d,%0d,%0d",
                                       i, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, m_rs, m_rt, m_rd);
                end
            end
            if (m_dp_known) begin
                n_checks++;
                if ({ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4} !== {m_d1, m_d2, m_imm, m_pc4}) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: d1=%h imm=%h required %h,%h",
                                       i, ID_EX_ReadData1, ID_EX_Imm, m_d1, m_imm);
                end
            end
`ifdef ID_EX_PERF_CNT_EN
            n_checks++;
            if (int'(stall_count) != m_stall || int'(flush_count) != m_flush) begin
                n_fail++; $display("FAIL rnd_counters[%0d]: actual=%0d,%0d required=%0d,%0d",
                                   i, stall_count, flush_count, m_stall, m_flush);
            end
`endif
        end
        reset = 1'b0; Flush = 1'b0; Hold = 1'b0;
    endtask

    initial begin
        m_rs = 0; m_rt = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc4 = 0;
        m_ctrl = 0; m_stall = 0; m_flush = 0; m_spec_known = 0; m_dp_known = 0;
        reset = 1'b1; Flush = 1'b0; Hold = 1'b0;
        drive('0, 0, 0, 0);
        tick();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_flush_lu();
        test_hold();
        test_reset_mid_stall();
        test_back_to_back();
        test_saturation();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
